// File: rtl/axi_ram_port_arbiter_if.sv
// Bundle of the write requester, read requester and single RAM port used by
// axi_ram_port_arbiter. The master side is the requester/RAM model and the slave side is the arbiter.
interface axi_ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_strb;
  logic                  wr_gnt;

  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [NB-1:0]         ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output wr_req, wr_addr, wr_data, wr_strb,
    output rd_req, rd_addr,
    output ram_rdata,
    input  wr_gnt, rd_gnt, rd_valid, rd_data,
    input  ram_addr, ram_wdata, ram_we
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_strb,
    input  rd_req, rd_addr,
    input  ram_rdata,
    output wr_gnt, rd_gnt, rd_valid, rd_data,
    output ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/axi_ram_port_arbiter.sv
// Shares one single-cycle RAM port between a write and a read requester.
// Bursts are capped at MAX_BURST beats under contention, and direct WR<->RD handovers are counted.
module axi_ram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_ram_port_arbiter_if.slave  bus,
  output logic [15:0]            switch_cnt
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  typedef enum logic {SRV_WR, SRV_RD} srv_t;

  state_t        state, state_next;
  srv_t          last_srv, last_srv_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          rd_valid_q;
  logic          write_beat, read_beat, do_switch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_srv   <= SRV_RD;
      cnt        <= '0;
      rd_valid_q <= 1'b0;
      switch_cnt <= 16'd0;
    end else begin
      state      <= state_next;
      last_srv   <= last_srv_next;
      cnt        <= cnt_next;
      rd_valid_q <= read_beat;
      if (do_switch && switch_cnt != 16'hFFFF)
        switch_cnt <= switch_cnt + 16'd1;
    end
  end

  // A burst ends when its requester lets go or when it has used its MAX_BURST
  // beats while the other side is waiting.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (bus.wr_req && bus.rd_req)
          state_next = (last_srv == SRV_RD) ? WR : RD;
        else if (bus.wr_req)
          state_next = WR;
        else if (bus.rd_req)
          state_next = RD;
      end
      WR: begin
        if (!bus.wr_req) begin
          state_next = bus.rd_req ? RD : IDLE;
          cnt_next   = '0;
        end else if (cnt == LAST_BEAT) begin
          state_next = bus.rd_req ? RD : WR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      RD: begin
        if (!bus.rd_req) begin
          state_next = bus.wr_req ? WR : IDLE;
          cnt_next   = '0;
        end else if (cnt == LAST_BEAT) begin
          state_next = bus.wr_req ? WR : RD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    last_srv_next = last_srv;
    if (state_next == WR)
      last_srv_next = SRV_WR;
    else if (state_next == RD)
      last_srv_next = SRV_RD;
    do_switch = ((state == WR) && (state_next == RD)) ||
                ((state == RD) && (state_next == WR));
  end

  // RAM outputs are zeroed outside beats so an idle port never writes.
  assign write_beat    = (state == WR) && bus.wr_req;
  assign read_beat     = (state == RD) && bus.rd_req;
  assign bus.wr_gnt    = write_beat;
  assign bus.rd_gnt    = read_beat;
  assign bus.ram_addr  = write_beat ? bus.wr_addr :
                         read_beat  ? bus.rd_addr : {ADDR_WIDTH{1'b0}};
  assign bus.ram_wdata = write_beat ? bus.wr_data : {DATA_WIDTH{1'b0}};
  assign bus.ram_we    = write_beat ? bus.wr_strb : {NB{1'b0}};
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_valid_q ? bus.ram_rdata : {DATA_WIDTH{1'b0}};
endmodule

// File: tb/tb_axi_ram_port_arbiter.sv
// Directed bench for axi_ram_port_arbiter: a MAX_BURST=8 instance with a byte-lane RAM model
// and a MAX_BURST=1 instance for alternation and switch counter saturation.
module tb_axi_ram_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NB = DW / BW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sc_a, sc_b;
  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] mem [0:255];

  always #5 clk = ~clk;

  axi_ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus_a ();
  axi_ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus_b ();

  axi_ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .MAX_BURST(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .switch_cnt(sc_a)
  );

  axi_ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .switch_cnt(sc_b)
  );

  assign bus_b.ram_rdata = '0;

  // RAM model with byte lanes; read data appears one cycle after the address.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      bus_a.ram_rdata <= '0;
    end else begin
      for (int b = 0; b < NB; b++)
        if (bus_a.ram_we[b]) mem[bus_a.ram_addr[7:0]][b*BW +: BW] <= bus_a.ram_wdata[b*BW +: BW];
      bus_a.ram_rdata <= mem[bus_a.ram_addr[7:0]];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_reset();
    rst_n = 1'b0;
    #1;
    check_output("rst_wr_gnt", 32'(bus_a.wr_gnt), 32'd0);
    check_output("rst_rd_gnt", 32'(bus_a.rd_gnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bus_a.wr_req = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.wr_strb = '0;
    bus_a.rd_req = 1'b0; bus_a.rd_addr = '0;
    bus_b.wr_req = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_strb = '0;
    bus_b.rd_req = 1'b0; bus_b.rd_addr = '0;

    // Contended bursts of 8, reset values checked with both requests high.
    bus_a.wr_req = 1'b1; bus_a.rd_req = 1'b1;
    bus_a.wr_addr = 16'h0001; bus_a.rd_addr = 16'h0002; bus_a.wr_data = 32'h12345678;
    rst_n = 1'b0;
    #2;
    check_output("rst_ram_we", 32'(bus_a.ram_we), 32'd0);
    check_output("rst_ram_addr", 32'(bus_a.ram_addr), 32'd0);
    check_output("rst_ram_wdata", bus_a.ram_wdata, 32'd0);
    check_output("rst_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    check_output("rst_rd_data", bus_a.rd_data, 32'd0);
    check_output("rst_switch_cnt", 32'(sc_a), 32'd0);
    apply_stimulus_reset();
    check_output("idle_wr_gnt", 32'(bus_a.wr_gnt), 32'd0);
    check_output("idle_rd_gnt", 32'(bus_a.rd_gnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("burst_wr_gnt", 32'(bus_a.wr_gnt), 32'd1);
      check_output("burst_wr_rd_gnt", 32'(bus_a.rd_gnt), 32'd0);
      check_output("burst_wr_addr", 32'(bus_a.ram_addr), 32'h0001);
      check_output("burst_zero_strb_we", 32'(bus_a.ram_we), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("burst_rd_gnt", 32'(bus_a.rd_gnt), 32'd1);
      check_output("burst_rd_wr_gnt", 32'(bus_a.wr_gnt), 32'd0);
      check_output("burst_rd_addr", 32'(bus_a.ram_addr), 32'h0002);
      check_output("burst_rd_wdata", bus_a.ram_wdata, 32'd0);
      if (i == 0) check_output("switch_cnt_1", 32'(sc_a), 32'd1);
    end
    tick();
    check_output("burst_back_to_wr", 32'(bus_a.wr_gnt), 32'd1);
    check_output("switch_cnt_2", 32'(sc_a), 32'd2);

    // Single strobed write then read-back of the same word.
    $display("[TB] write/read-back");
    bus_a.wr_req = 1'b1; bus_a.rd_req = 1'b0;
    bus_a.wr_addr = 16'h0010; bus_a.wr_data = 32'hDEADBEEF; bus_a.wr_strb = 4'b0101;
    apply_stimulus_reset();
    tick();
    check_output("wr_gnt", 32'(bus_a.wr_gnt), 32'd1);
    check_output("wr_ram_we", 32'(bus_a.ram_we), 32'h5);
    check_output("wr_ram_addr", 32'(bus_a.ram_addr), 32'h0010);
    check_output("wr_ram_wdata", bus_a.ram_wdata, 32'hDEADBEEF);
    tick();
    bus_a.wr_req = 1'b0; bus_a.wr_strb = '0;
    bus_a.rd_req = 1'b1; bus_a.rd_addr = 16'h0010;
    #1;
    check_output("wr_done_we", 32'(bus_a.ram_we), 32'd0);
    check_output("wr_done_gnt", 32'(bus_a.wr_gnt), 32'd0);
    tick();
    check_output("rd_gnt", 32'(bus_a.rd_gnt), 32'd1);
    check_output("rd_ram_addr", 32'(bus_a.ram_addr), 32'h0010);
    check_output("rd_valid_early", 32'(bus_a.rd_valid), 32'd0);
    tick();
    bus_a.rd_req = 1'b0;
    #1;
    check_output("rd_valid", 32'(bus_a.rd_valid), 32'd1);
    check_output("rd_data", bus_a.rd_data, 32'h00AD00EF);
    tick();
    check_output("rd_valid_drop", 32'(bus_a.rd_valid), 32'd0);
    check_output("rd_data_zero", bus_a.rd_data, 32'd0);
    check_output("wr_rd_switch", 32'(sc_a), 32'd1);

    // Lone reader streams without interruption.
    $display("[TB] lone reader");
    bus_a.rd_req = 1'b1; bus_a.rd_addr = 16'h0020;
    apply_stimulus_reset();
    check_output("lone_idle", 32'(bus_a.rd_gnt), 32'd0);
    for (int i = 0; i < 19; i++) begin
      tick();
      check_output("lone_rd_gnt", 32'(bus_a.rd_gnt), 32'd1);
      check_output("lone_wr_gnt", 32'(bus_a.wr_gnt), 32'd0);
    end
    check_output("lone_switch_cnt", 32'(sc_a), 32'd0);

    // Writer drops after 3 beats: reader takes over directly.
    $display("[TB] early writer release");
    bus_a.wr_req = 1'b1; bus_a.rd_req = 1'b1; bus_a.wr_addr = 16'h0030; bus_a.wr_strb = '0;
    apply_stimulus_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("early_wr_gnt", 32'(bus_a.wr_gnt), 32'd1);
    end
    tick();
    bus_a.wr_req = 1'b0;
    #1;
    check_output("gap_wr_gnt", 32'(bus_a.wr_gnt), 32'd0);
    check_output("gap_rd_gnt", 32'(bus_a.rd_gnt), 32'd0);
    tick();
    check_output("handover_rd_gnt", 32'(bus_a.rd_gnt), 32'd1);
    check_output("handover_switch", 32'(sc_a), 32'd1);

    // Reset during read beat 4 aborts the burst at once.
    tick();
    check_output("beat2_rd_valid", 32'(bus_a.rd_valid), 32'd1);
    tick();
    tick();
    check_output("beat4_rd_gnt", 32'(bus_a.rd_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("abort_rd_gnt", 32'(bus_a.rd_gnt), 32'd0);
    check_output("abort_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    check_output("abort_ram_addr", 32'(bus_a.ram_addr), 32'd0);
    check_output("abort_switch", 32'(sc_a), 32'd0);
    bus_a.wr_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("abort_idle_wr", 32'(bus_a.wr_gnt), 32'd0);
    check_output("abort_idle_rd", 32'(bus_a.rd_gnt), 32'd0);
    tick();
    check_output("abort_writer_first", 32'(bus_a.wr_gnt), 32'd1);
    check_output("abort_reader_waits", 32'(bus_a.rd_gnt), 32'd0);

    // MAX_BURST=1: alternation every cycle and switch counter saturation.
    $display("[TB] alternation and saturation");
    bus_a.wr_req = 1'b0; bus_a.rd_req = 1'b0;
    bus_b.wr_req = 1'b1; bus_b.rd_req = 1'b1;
    bus_b.wr_addr = 16'h0003; bus_b.rd_addr = 16'h0004; bus_b.wr_strb = 4'hF;
    apply_stimulus_reset();
    check_output("alt_idle", 32'(bus_b.wr_gnt | bus_b.rd_gnt), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_output("alt_wr_gnt", 32'(bus_b.wr_gnt), 32'(k % 2));
      check_output("alt_rd_gnt", 32'(bus_b.rd_gnt), 32'(1 - (k % 2)));
      check_output("alt_switch", 32'(sc_b), 32'(k - 1));
    end
    repeat (65540) @(posedge clk);
    #1;
    check_output("sat_switch", 32'(sc_b), 32'hFFFF);
    tick();
    check_output("sat_hold", 32'(sc_b), 32'hFFFF);
    check_output("sat_one_grant", 32'(bus_b.wr_gnt ^ bus_b.rd_gnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_ram_port_arbiter.md
AXI_RAM_PORT_ARBITER -- requirements
Module: axi_ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width; a multiple of BYTE_WIDTH.
REQ-003 The block SHALL have parameter BYTE_WIDTH, default 8, byte-lane width; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-004 The block SHALL have parameter MAX_BURST, default 8, maximum consecutive beats per grant under contention; value >= 1.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have ports wr_req (in, 1), wr_addr (in, ADDR_WIDTH), wr_data (in, DATA_WIDTH), wr_strb (in, NB) and wr_gnt (out, 1), forming the write requester.
REQ-008 The block SHALL have ports rd_req (in, 1), rd_addr (in, ADDR_WIDTH), rd_gnt (out, 1), rd_valid (out, 1) and rd_data (out, DATA_WIDTH), forming the read requester.
REQ-009 The block SHALL have ports ram_addr (out, ADDR_WIDTH), ram_wdata (out, DATA_WIDTH), ram_we (out, NB, per-byte write enable) and ram_rdata (in, DATA_WIDTH, valid 1 cycle after the address), forming the single RAM port.
REQ-010 The block SHALL have port switch_cnt, output, 16 bits, saturating count of WR<->RD direct grant switches.

Function
REQ-011 The FSM SHALL have the states IDLE, WR and RD, plus a last_srv flag (WR/RD) and a beat counter of width max(1, clog2(MAX_BURST)).
REQ-012 wr_gnt SHALL equal (state==WR && wr_req), and rd_gnt SHALL equal (state==RD && rd_req); both are combinational.
REQ-013 A beat SHALL be any cycle with a grant high; the requester's address and data are consumed in that cycle.
REQ-014 In IDLE, the FSM SHALL go to WR if only wr_req is high, to RD if only rd_req is high, and, if both are high, to the state opposite last_srv; if neither is high it SHALL stay in IDLE; no grant is issued in IDLE (1-cycle arbitration latency).
REQ-015 In WR with wr_req low, the FSM SHALL go to RD if rd_req is high, else to IDLE, and the counter SHALL clear.
REQ-016 In WR, a beat with counter < MAX_BURST-1 SHALL increment the counter.
REQ-017 In WR, a beat with counter == MAX_BURST-1 SHALL go to RD if rd_req is high, else stay in WR; the counter SHALL clear in both cases.
REQ-018 RD SHALL behave symmetrically to WR with wr/rd exchanged.
REQ-019 On every entry to WR or RD, last_srv SHALL be set to that state and the counter SHALL be cleared.
REQ-020 ram_addr SHALL be wr_addr on a write beat, rd_addr on a read beat, else 0.
REQ-021 ram_wdata SHALL be wr_data on a write beat, else 0.
REQ-022 ram_we SHALL be wr_strb on a write beat, else 0.
REQ-023 A write beat with wr_strb == 0 SHALL still count as a beat but SHALL write nothing.
REQ-024 rd_valid SHALL be rd_gnt registered by one cycle, and rd_data SHALL equal ram_rdata while rd_valid is high, else 0.
REQ-025 switch_cnt SHALL increment on each direct WR->RD or RD->WR transition and SHALL saturate at 16'hFFFF without wrapping.
REQ-026 Transitions through IDLE SHALL NOT be counted in switch_cnt.
REQ-027 wr_gnt and rd_gnt SHALL never be high in the same cycle.
REQ-028 With MAX_BURST == 1 and both requests held high, the grant SHALL alternate every cycle.

Reset
REQ-029 While rst_n is low, the block SHALL hold state=IDLE, last_srv=RD, counter=0, rd_valid=0 and switch_cnt=0, which forces wr_gnt=0, rd_gnt=0, ram_we=0, ram_addr=0, ram_wdata=0 and rd_data=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously), drop any pending rd_valid and write nothing further.
REQ-031 After reset release, the first contended grant SHALL go to WR, because last_srv=RD.

Verification
REQ-032 Reset, then hold wr_req=rd_req=1 with MAX_BURST=8 -> cycle 1 IDLE; wr_gnt for 8 cycles; then rd_gnt for 8 cycles; switch_cnt increments to 1, then 2.
REQ-033 Single write to addr 0x0010 with data 0xDEADBEEF and strb 4'b0101, then a read of 0x0010 -> ram_we=4'b0101 for one cycle; rd_valid high 1 cycle after rd_gnt, with rd_data equal to the RAM model content 0x00AD00EF (model pre-cleared).
REQ-034 Only rd_req high for 20 cycles -> rd_gnt continuous for 19 cycles after the 1-cycle IDLE latency, no switch, switch_cnt=0.
REQ-035 wr_req drops after 3 beats while rd_req is high -> RD is entered on the next cycle, with no IDLE cycle and no grant gap beyond 1 cycle.
REQ-036 rst_n pulsed low during read beat 4 -> rd_gnt and rd_valid are 0 immediately, state is IDLE, and the next contended grant goes to the writer.
REQ-037 Force switch_cnt to near saturation (MAX_BURST=1, 65540 contended cycles) -> switch_cnt holds at 0xFFFF.
